// File: rtl/msgdma2axi4_bridge.sv
// Bridges an mSGDMA Avalon-MM read agent and write agent onto one AXI4 manager port.
// Writes are serialised through a two-state command/data FSM; reads are passed straight
// through with only an outstanding-burst limit.
module msgdma2axi4_bridge #(
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned ADDR_W     = 36,
    parameter int unsigned BCNT_W     = 8,
    parameter int unsigned MAX_WR_OUT = 4,
    parameter int unsigned MAX_RD_OUT = 4,
    parameter logic [3:0]  AXCACHE    = 4'b0000,
    parameter logic [2:0]  AXPROT     = 3'b011
) (
    input  logic                clk,
    input  logic                reset,

    // Avalon-MM read agent
    input  logic [ADDR_W-1:0]   s0_read_address,
    input  logic                s0_read_read,
    input  logic [DATA_W/8-1:0] s0_read_byteenable,
    input  logic [BCNT_W-1:0]   s0_read_burstcount,
    output logic [DATA_W-1:0]   s0_read_readdata,
    output logic                s0_read_readdatavalid,
    output logic                s0_read_waitrequest,

    // Avalon-MM write agent
    input  logic [ADDR_W-1:0]   s1_write_address,
    input  logic                s1_write_write,
    input  logic [DATA_W/8-1:0] s1_write_byteenable,
    input  logic [DATA_W-1:0]   s1_write_writedata,
    input  logic [BCNT_W-1:0]   s1_write_burstcount,
    output logic                s1_write_waitrequest,

    // AXI4 manager: write address
    output logic [0:0]          m0_awid,
    output logic [ADDR_W-1:0]   m0_awaddr,
    output logic [7:0]          m0_awlen,
    output logic [2:0]          m0_awsize,
    output logic [1:0]          m0_awburst,
    output logic                m0_awlock,
    output logic [3:0]          m0_awcache,
    output logic [2:0]          m0_awprot,
    output logic                m0_awvalid,
    input  logic                m0_awready,
    // write data
    output logic [DATA_W-1:0]   m0_wdata,
    output logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_wlast,
    output logic                m0_wvalid,
    input  logic                m0_wready,
    // write response
    input  logic [0:0]          m0_bid,
    input  logic [1:0]          m0_bresp,
    input  logic                m0_bvalid,
    output logic                m0_bready,
    // read address
    output logic [0:0]          m0_arid,
    output logic [ADDR_W-1:0]   m0_araddr,
    output logic [7:0]          m0_arlen,
    output logic [2:0]          m0_arsize,
    output logic [1:0]          m0_arburst,
    output logic                m0_arlock,
    output logic [3:0]          m0_arcache,
    output logic [2:0]          m0_arprot,
    output logic                m0_arvalid,
    input  logic                m0_arready,
    // read data
    input  logic [0:0]          m0_rid,
    input  logic [DATA_W-1:0]   m0_rdata,
    input  logic [1:0]          m0_rresp,
    input  logic                m0_rlast,
    input  logic                m0_rvalid,
    output logic                m0_rready,

    // status
    input  logic                err_clear,
    output logic                wr_err,
    output logic                rd_err,
    output logic                wr_idle,
    output logic                rd_idle
);

    localparam logic [2:0] AxSize = 3'($clog2(DATA_W / 8));
    localparam logic [3:0] MaxWr  = 4'(MAX_WR_OUT);
    localparam logic [3:0] MaxRd  = 4'(MAX_RD_OUT);

    typedef enum logic {W_CMD, W_DATA} wr_state_e;

    wr_state_e         state_q, state_d;
    logic [BCNT_W-1:0] beats_q, beats_d;
    logic [3:0]        wr_out_q, wr_out_d;
    logic [3:0]        rd_out_q, rd_out_d;
    logic              wr_err_q, wr_err_d;
    logic              rd_err_q, rd_err_d;

    logic              wr_room, rd_room;
    logic              aw_hs, b_hs, ar_hs, r_last_hs;
    logic [BCNT_W-1:0] wr_bcnt_eff;

    // burstcount 0 is treated as a single beat; len is truncated to the 8-bit AXI field
    function automatic logic [7:0] axi_len(input logic [BCNT_W-1:0] bc);
        logic [8:0] ext;
        ext = 9'(bc);
        if (ext == 9'd0) begin
            return 8'd0;
        end
        return 8'(ext - 9'd1);
    endfunction

    assign wr_room     = (wr_out_q < MaxWr);
    assign rd_room     = (rd_out_q < MaxRd);
    assign wr_bcnt_eff = (s1_write_burstcount == '0) ? BCNT_W'(1) : s1_write_burstcount;

    // Fixed AXI attributes and pass-through fields
    assign m0_awid    = 1'b0;
    assign m0_awaddr  = s1_write_address;
    assign m0_awlen   = axi_len(s1_write_burstcount);
    assign m0_awsize  = AxSize;
    assign m0_awburst = 2'b01;
    assign m0_awlock  = 1'b0;
    assign m0_awcache = AXCACHE;
    assign m0_awprot  = AXPROT;
    assign m0_wdata   = s1_write_writedata;
    assign m0_wstrb   = s1_write_byteenable;
    assign m0_wlast   = (beats_q == BCNT_W'(1));
    assign m0_bready  = 1'b1;

    assign m0_arid    = 1'b0;
    assign m0_araddr  = s0_read_address;
    assign m0_arlen   = axi_len(s0_read_burstcount);
    assign m0_arsize  = AxSize;
    assign m0_arburst = 2'b01;
    assign m0_arlock  = 1'b0;
    assign m0_arcache = AXCACHE;
    assign m0_arprot  = AXPROT;
    assign m0_arvalid = s0_read_read & rd_room;
    assign m0_rready  = 1'b1;

    assign s0_read_waitrequest   = ~(m0_arready & rd_room);
    assign s0_read_readdata      = m0_rdata;
    assign s0_read_readdatavalid = m0_rvalid;

    assign aw_hs     = m0_awvalid & m0_awready;
    assign b_hs      = m0_bvalid;
    assign ar_hs     = m0_arvalid & m0_arready;
    assign r_last_hs = m0_rvalid & m0_rlast;

    assign wr_err  = wr_err_q;
    assign rd_err  = rd_err_q;
    assign wr_idle = (state_q == W_CMD) & (wr_out_q == 4'd0);
    assign rd_idle = (rd_out_q == 4'd0);

    // Write FSM next state and the write-side handshake outputs
    always_comb begin
        state_d              = state_q;
        beats_d              = beats_q;
        m0_awvalid           = 1'b0;
        m0_wvalid            = 1'b0;
        s1_write_waitrequest = 1'b1;
        case (state_q)
            W_CMD: begin
                // held low during reset so nothing is offered before the bridge is live
                m0_awvalid = s1_write_write & wr_room & ~reset;
                if (m0_awvalid && m0_awready) begin
                    beats_d = wr_bcnt_eff;
                    state_d = W_DATA;
                end
            end
            W_DATA: begin
                m0_wvalid            = s1_write_write;
                s1_write_waitrequest = ~m0_wready;
                if (m0_wvalid && m0_wready) begin
                    beats_d = beats_q - BCNT_W'(1);
                    if (beats_q == BCNT_W'(1)) begin
                        state_d = W_CMD;
                    end
                end
            end
            default: state_d = W_CMD;
        endcase
    end

    // Outstanding counters saturate at 0 so a spurious response cannot wrap them
    always_comb begin
        wr_out_d = wr_out_q;
        rd_out_d = rd_out_q;
        if (aw_hs && !b_hs) begin
            wr_out_d = wr_out_q + 4'd1;
        end else if (!aw_hs && b_hs && (wr_out_q != 4'd0)) begin
            wr_out_d = wr_out_q - 4'd1;
        end
        if (ar_hs && !r_last_hs) begin
            rd_out_d = rd_out_q + 4'd1;
        end else if (!ar_hs && r_last_hs && (rd_out_q != 4'd0)) begin
            rd_out_d = rd_out_q - 4'd1;
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear
    always_comb begin
        wr_err_d = (b_hs & m0_bresp[1]) | (wr_err_q & ~err_clear);
        rd_err_d = (m0_rvalid & m0_rresp[1]) | (rd_err_q & ~err_clear);
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= W_CMD;
            beats_q  <= '0;
            wr_out_q <= 4'd0;
            rd_out_q <= 4'd0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beats_q  <= beats_d;
            wr_out_q <= wr_out_d;
            rd_out_q <= rd_out_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    // IDs are single-valued and read byte enables have no AXI counterpart
    logic unused_inputs;
    assign unused_inputs = ^{s0_read_byteenable, m0_bid, m0_rid, m0_bresp[0], m0_rresp[0]};

endmodule

// File: tb/tb_msgdma2axi4_bridge.sv
// Self-checking bench for msgdma2axi4_bridge (DATA_W 512, MAX_WR_OUT 2, MAX_RD_OUT 4).
module tb_msgdma2axi4_bridge;

    localparam int DW = 512;
    localparam int AW = 36;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] s0_read_address;
    logic          s0_read_read;
    logic [BW-1:0] s0_read_byteenable;
    logic [7:0]    s0_read_burstcount;
    logic [DW-1:0] s0_read_readdata;
    logic          s0_read_readdatavalid;
    logic          s0_read_waitrequest;
    logic [AW-1:0] s1_write_address;
    logic          s1_write_write;
    logic [BW-1:0] s1_write_byteenable;
    logic [DW-1:0] s1_write_writedata;
    logic [7:0]    s1_write_burstcount;
    logic          s1_write_waitrequest;
    logic [0:0]    m0_awid, m0_bid, m0_arid, m0_rid;
    logic [AW-1:0] m0_awaddr, m0_araddr;
    logic [7:0]    m0_awlen, m0_arlen;
    logic [2:0]    m0_awsize, m0_arsize, m0_awprot, m0_arprot;
    logic [1:0]    m0_awburst, m0_arburst, m0_bresp, m0_rresp;
    logic          m0_awlock, m0_arlock;
    logic [3:0]    m0_awcache, m0_arcache;
    logic          m0_awvalid, m0_awready, m0_arvalid, m0_arready;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [BW-1:0] m0_wstrb;
    logic          m0_wlast, m0_wvalid, m0_wready;
    logic          m0_bvalid, m0_bready;
    logic          m0_rlast, m0_rvalid, m0_rready;
    logic          err_clear, wr_err, rd_err, wr_idle, rd_idle;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_wdata_q[$];
    logic [BW-1:0] exp_wstrb_q[$];
    logic [DW-1:0] exp_rdata_q[$];

    msgdma2axi4_bridge #(
        .DATA_W(DW), .ADDR_W(AW), .BCNT_W(8), .MAX_WR_OUT(2), .MAX_RD_OUT(4),
        .AXCACHE(4'b0000), .AXPROT(3'b011)
    ) dut (
        .clk(clk), .reset(reset),
        .s0_read_address(s0_read_address), .s0_read_read(s0_read_read),
        .s0_read_byteenable(s0_read_byteenable), .s0_read_burstcount(s0_read_burstcount),
        .s0_read_readdata(s0_read_readdata), .s0_read_readdatavalid(s0_read_readdatavalid),
        .s0_read_waitrequest(s0_read_waitrequest),
        .s1_write_address(s1_write_address), .s1_write_write(s1_write_write),
        .s1_write_byteenable(s1_write_byteenable), .s1_write_writedata(s1_write_writedata),
        .s1_write_burstcount(s1_write_burstcount), .s1_write_waitrequest(s1_write_waitrequest),
        .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awsize(m0_awsize),
        .m0_awburst(m0_awburst), .m0_awlock(m0_awlock), .m0_awcache(m0_awcache),
        .m0_awprot(m0_awprot), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast), .m0_wvalid(m0_wvalid),
        .m0_wready(m0_wready), .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid),
        .m0_bready(m0_bready),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_arlock(m0_arlock), .m0_arcache(m0_arcache),
        .m0_arprot(m0_arprot), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .err_clear(err_clear), .wr_err(wr_err), .rd_err(rd_err),
        .wr_idle(wr_idle), .rd_idle(rd_idle)
    );

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // Data the bench's AXI subordinate returns for a given address/beat
    function automatic logic [DW-1:0] rd_pattern(input logic [AW-1:0] a, input int beat);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = a[31:0] ^ {16'(beat), 16'(i * 7 + 1)};
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; s1_write_write = 1'b1; s1_write_burstcount = 8'd1; s0_read_read = 1'b1;
        s0_read_burstcount = 8'd1; m0_awready = 1'b1; m0_wready = 1'b1; m0_arready = 1'b0;
        @(negedge clk);
        n_checks++; if (s1_write_waitrequest !== 1'b1) begin n_fail++;
            $display("FAIL reset_wr_waitreq: got %b want 1", s1_write_waitrequest); end
        n_checks++; if (m0_awvalid !== 1'b0) begin n_fail++;
            $display("FAIL reset_awvalid: got %b want 0", m0_awvalid); end
        n_checks++; if (m0_wvalid !== 1'b0) begin n_fail++;
            $display("FAIL reset_wvalid: got %b want 0", m0_wvalid); end
        n_checks++; if (m0_arvalid !== 1'b1) begin n_fail++;
            $display("FAIL reset_arvalid: got %b want 1 (=read)", m0_arvalid); end
        n_checks++; if ({wr_idle, rd_idle} !== 2'b11) begin n_fail++;
            $display("FAIL reset_idle: got %b want 11", {wr_idle, rd_idle}); end
        n_checks++; if ({wr_err, rd_err} !== 2'b00) begin n_fail++;
            $display("FAIL reset_err: got %b want 00", {wr_err, rd_err}); end
        n_checks++; if ({m0_bready, m0_rready, m0_awid, m0_arid, m0_awlock, m0_arlock}
                        !== 6'b110000) begin n_fail++;
            $display("FAIL reset_ties: got %b want 110000",
                     {m0_bready, m0_rready, m0_awid, m0_arid, m0_awlock, m0_arlock}); end
        step();
        reset = 1'b0; s1_write_write = 1'b0; s0_read_read = 1'b0; m0_awready = 1'b0;
        m0_wready = 1'b0;
        @(negedge clk);
        n_checks++; if (m0_arvalid !== 1'b0) begin n_fail++;
            $display("FAIL post_reset_arvalid: got %b want 0", m0_arvalid); end
        step();
    endtask

    // Single-beat writes, with burstcount 1 and burstcount 0
    task automatic test_single_write();
        logic [AW-1:0] a;
        logic [DW-1:0] d, ed;
        logic [BW-1:0] be, es;
        for (int k = 0; k < 2; k++) begin
            a = 36'h1_2345_6780 + 36'(k * 64);
            d = rand_data();
            be = {$urandom(), $urandom()};
            exp_wdata_q.push_back(d); exp_wstrb_q.push_back(be);
            s1_write_address = a; s1_write_burstcount = (k == 0) ? 8'd1 : 8'd0;
            s1_write_writedata = d; s1_write_byteenable = be; s1_write_write = 1'b1;
            m0_awready = 1'b1; m0_wready = 1'b1;
            @(negedge clk);
            n_checks++; if (m0_awvalid !== 1'b1 || m0_awaddr !== a || m0_awlen !== 8'd0) begin
                n_fail++; $display("FAIL sw_aw: got v=%b addr=%h len=%0d want v=1 addr=%h len=0",
                                   m0_awvalid, m0_awaddr, m0_awlen, a); end
            n_checks++; if ({m0_awsize, m0_awburst, m0_awcache, m0_awprot} !== 12'b110_01_0000_011)
            begin n_fail++; $display("FAIL sw_aw_attr: got %b want 110010000011",
                                     {m0_awsize, m0_awburst, m0_awcache, m0_awprot}); end
            n_checks++; if (m0_wvalid !== 1'b0 || s1_write_waitrequest !== 1'b1) begin n_fail++;
                $display("FAIL sw_cmd_phase: got wvalid=%b waitreq=%b want 0 1",
                         m0_wvalid, s1_write_waitrequest); end
            step();
            @(negedge clk);
            n_checks++; if (m0_wvalid !== 1'b1 || m0_wlast !== 1'b1 || s1_write_waitrequest !== 1'b0)
            begin n_fail++; $display("FAIL sw_w: got wvalid=%b wlast=%b waitreq=%b want 1 1 0",
                                     m0_wvalid, m0_wlast, s1_write_waitrequest); end
            if (m0_wvalid && m0_wready) begin
                n_checks++;
                if (exp_wdata_q.size() == 0) begin n_fail++;
                    $display("FAIL sw_scoreboard: got unexpected beat want none"); end
                else begin
                    ed = exp_wdata_q.pop_front(); es = exp_wstrb_q.pop_front();
                    if (m0_wdata !== ed || m0_wstrb !== es) begin n_fail++;
                        $display("FAIL sw_wdata: got strb=%h data=%h want strb=%h data=%h",
                                 m0_wstrb, m0_wdata, es, ed); end
                end
            end
            step();
            s1_write_write = 1'b0;
            @(negedge clk);
            n_checks++; if (wr_idle !== 1'b0 || s1_write_waitrequest !== 1'b1) begin n_fail++;
                $display("FAIL sw_b_pending: got idle=%b waitreq=%b want 0 1",
                         wr_idle, s1_write_waitrequest); end
            m0_bvalid = 1'b1; m0_bresp = 2'b00;
            step();
            m0_bvalid = 1'b0;
            @(negedge clk);
            n_checks++; if (wr_idle !== 1'b1 || wr_err !== 1'b0) begin n_fail++;
                $display("FAIL sw_done: got idle=%b err=%b want 1 0", wr_idle, wr_err); end
            step();
        end
    endtask

    // Burst of 4 with awready stalled once and wready toggling every cycle
    task automatic test_burst_write();
        logic [DW-1:0] d[4];
        logic [DW-1:0] ed;
        logic [BW-1:0] es;
        int beat;
        for (int i = 0; i < 4; i++) begin
            d[i] = rand_data();
            exp_wdata_q.push_back(d[i]); exp_wstrb_q.push_back(BW'(64'hFFFF_0000_FFFF_0000 >> i));
        end
        s1_write_address = 36'h4_0000_0000; s1_write_burstcount = 8'd4; s1_write_write = 1'b1;
        s1_write_writedata = d[0]; s1_write_byteenable = BW'(64'hFFFF_0000_FFFF_0000);
        m0_awready = 1'b0; m0_wready = 1'b0;
        @(negedge clk);
        n_checks++; if (m0_awvalid !== 1'b1 || s1_write_waitrequest !== 1'b1) begin n_fail++;
            $display("FAIL bw_aw_stall: got v=%b waitreq=%b want 1 1",
                     m0_awvalid, s1_write_waitrequest); end
        step();
        m0_awready = 1'b1;
        @(negedge clk);
        n_checks++; if (m0_awvalid !== 1'b1 || m0_awlen !== 8'd3) begin n_fail++;
            $display("FAIL bw_aw: got v=%b len=%0d want 1 3", m0_awvalid, m0_awlen); end
        step();
        m0_awready = 1'b0;
        beat = 0;
        for (int c = 0; c < 20 && beat < 4; c++) begin
            m0_wready = c[0];
            s1_write_writedata = d[beat];
            s1_write_byteenable = BW'(64'hFFFF_0000_FFFF_0000 >> beat);
            @(negedge clk);
            n_checks++; if (s1_write_waitrequest !== ~m0_wready || m0_wvalid !== 1'b1) begin
                n_fail++; $display("FAIL bw_waitreq: got waitreq=%b wvalid=%b want %b 1",
                                   s1_write_waitrequest, m0_wvalid, ~m0_wready); end
            n_checks++; if (m0_wlast !== (beat == 3)) begin n_fail++;
                $display("FAIL bw_wlast: beat %0d got %b want %b", beat, m0_wlast, beat == 3); end
            if (m0_wvalid && m0_wready) begin
                n_checks++;
                if (exp_wdata_q.size() == 0) begin n_fail++;
                    $display("FAIL bw_scoreboard: got unexpected beat want none"); end
                else begin
                    ed = exp_wdata_q.pop_front(); es = exp_wstrb_q.pop_front();
                    if (m0_wdata !== ed || m0_wstrb !== es) begin n_fail++;
                        $display("FAIL bw_wdata: beat %0d got strb=%h want strb=%h (data differs=%b)",
                                 beat, m0_wstrb, es, m0_wdata !== ed); end
                end
                beat++;
            end
            step();
        end
        n_checks++; if (beat != 4) begin n_fail++;
            $display("FAIL bw_beats: got %0d want 4", beat); end
        s1_write_write = 1'b0; m0_wready = 1'b0;
        @(negedge clk);
        n_checks++; if (m0_wvalid !== 1'b0 || wr_idle !== 1'b0) begin n_fail++;
            $display("FAIL bw_after: got wvalid=%b idle=%b want 0 0", m0_wvalid, wr_idle); end
        m0_bvalid = 1'b1; m0_bresp = 2'b00;
        step();
        m0_bvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (wr_idle !== 1'b1) begin n_fail++;
            $display("FAIL bw_idle: got %b want 1", wr_idle); end
        step();
    endtask

    // With two B responses withheld the third AW must wait for a B handshake
    task automatic test_wr_outstanding();
        s1_write_burstcount = 8'd1; m0_awready = 1'b1; m0_wready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s1_write_address = 36'h0_0000_1000 + 36'(k * 64); s1_write_write = 1'b1;
            @(negedge clk);
            n_checks++; if (m0_awvalid !== 1'b1) begin n_fail++;
                $display("FAIL wo_aw%0d: got %b want 1", k, m0_awvalid); end
            step();
            step();
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (m0_awvalid !== 1'b0 || s1_write_waitrequest !== 1'b1) begin n_fail++;
                $display("FAIL wo_blocked: got v=%b waitreq=%b want 0 1",
                         m0_awvalid, s1_write_waitrequest); end
            step();
        end
        m0_bvalid = 1'b1; m0_bresp = 2'b00;
        @(negedge clk);
        n_checks++; if (m0_awvalid !== 1'b0) begin n_fail++;
            $display("FAIL wo_same_cycle: got %b want 0", m0_awvalid); end
        step();
        m0_bvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (m0_awvalid !== 1'b1) begin n_fail++;
            $display("FAIL wo_released: got %b want 1", m0_awvalid); end
        step();
        step();
        s1_write_write = 1'b0;
        m0_bvalid = 1'b1;
        step();
        @(negedge clk);
        n_checks++; if (wr_idle !== 1'b0) begin n_fail++;
            $display("FAIL wo_one_left: got idle=%b want 0", wr_idle); end
        step();
        m0_bvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (wr_idle !== 1'b1) begin n_fail++;
            $display("FAIL wo_drained: got idle=%b want 1", wr_idle); end
        step();
    endtask

    // Read burst of 8 with one idle gap in the R stream
    task automatic test_read_burst();
        logic [AW-1:0] a;
        logic [DW-1:0] ed;
        logic          drove;
        int            beat;
        a = 36'h8_0000_1000;
        s0_read_address = a; s0_read_burstcount = 8'd8; s0_read_read = 1'b1; m0_arready = 1'b0;
        @(negedge clk);
        n_checks++; if (m0_arvalid !== 1'b1 || s0_read_waitrequest !== 1'b1) begin n_fail++;
            $display("FAIL rb_stall: got v=%b waitreq=%b want 1 1",
                     m0_arvalid, s0_read_waitrequest); end
        step();
        m0_arready = 1'b1;
        @(negedge clk);
        n_checks++; if (m0_arvalid !== 1'b1 || s0_read_waitrequest !== 1'b0 || m0_araddr !== a ||
                        m0_arlen !== 8'd7 || m0_arsize !== 3'd6 || m0_arburst !== 2'b01) begin
            n_fail++; $display("FAIL rb_ar: got v=%b wr=%b addr=%h len=%0d size=%0d burst=%b want 1 0 %h 7 6 01",
                               m0_arvalid, s0_read_waitrequest, m0_araddr, m0_arlen, m0_arsize,
                               m0_arburst, a); end
        n_checks++; if ({m0_arcache, m0_arprot} !== 7'b0000_011) begin n_fail++;
            $display("FAIL rb_attr: got %b want 0000011", {m0_arcache, m0_arprot}); end
        for (int i = 0; i < 8; i++) exp_rdata_q.push_back(rd_pattern(a, i));
        step();
        s0_read_read = 1'b0; m0_arready = 1'b0;
        beat = 0;
        for (int c = 0; c < 12 && beat < 8; c++) begin
            drove = (c != 4);
            m0_rvalid = drove; m0_rdata = rd_pattern(a, beat); m0_rlast = drove && (beat == 7);
            m0_rresp = 2'b00;
            @(negedge clk);
            n_checks++; if (s0_read_readdatavalid !== drove || rd_idle !== 1'b0) begin n_fail++;
                $display("FAIL rb_valid: cycle %0d got rdv=%b idle=%b want %b 0",
                         c, s0_read_readdatavalid, rd_idle, drove); end
            if (s0_read_readdatavalid) begin
                n_checks++;
                if (exp_rdata_q.size() == 0) begin n_fail++;
                    $display("FAIL rb_scoreboard: got unexpected beat want none"); end
                else begin
                    ed = exp_rdata_q.pop_front();
                    if (s0_read_readdata !== ed) begin n_fail++;
                        $display("FAIL rb_data: beat %0d got %h want %h", beat,
                                 s0_read_readdata[63:0], ed[63:0]); end
                end
            end
            if (drove) beat++;
            step();
        end
        m0_rvalid = 1'b0; m0_rlast = 1'b0;
        @(negedge clk);
        n_checks++; if (rd_idle !== 1'b1 || beat != 8) begin n_fail++;
            $display("FAIL rb_done: got idle=%b beats=%0d want 1 8", rd_idle, beat); end
        step();
    endtask

    // Four single reads fill the read window; the fifth waits for an rlast
    task automatic test_rd_outstanding();
        logic [AW-1:0] base;
        logic [DW-1:0] ed;
        base = 36'h2_0000_0000;
        s0_read_burstcount = 8'd1; s0_read_read = 1'b1; m0_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s0_read_address = base + 36'(k * 64);
            @(negedge clk);
            n_checks++; if (m0_arvalid !== 1'b1 || m0_araddr !== base + 36'(k * 64)) begin
                n_fail++; $display("FAIL ro_ar%0d: got v=%b addr=%h want 1 %h", k, m0_arvalid,
                                   m0_araddr, base + 36'(k * 64)); end
            exp_rdata_q.push_back(rd_pattern(base + 36'(k * 64), 0));
            step();
        end
        s0_read_address = base + 36'(4 * 64);
        @(negedge clk);
        n_checks++; if (m0_arvalid !== 1'b0 || s0_read_waitrequest !== 1'b1) begin n_fail++;
            $display("FAIL ro_full: got v=%b waitreq=%b want 0 1", m0_arvalid, s0_read_waitrequest);
        end
        step();
        for (int k = 0; k < 5; k++) begin
            m0_rvalid = 1'b1; m0_rlast = 1'b1; m0_rresp = 2'b00;
            m0_rdata = rd_pattern(base + 36'(k * 64), 0);
            @(negedge clk);
            if (k == 0) begin
                n_checks++; if (m0_arvalid !== 1'b0) begin n_fail++;
                    $display("FAIL ro_same_cycle: got %b want 0", m0_arvalid); end
            end
            n_checks++;
            if (exp_rdata_q.size() == 0) begin n_fail++;
                $display("FAIL ro_scoreboard: got beat %0d want none", k); end
            else begin
                ed = exp_rdata_q.pop_front();
                if (s0_read_readdata !== ed || s0_read_readdatavalid !== 1'b1) begin n_fail++;
                    $display("FAIL ro_data%0d: got v=%b %h want 1 %h", k, s0_read_readdatavalid,
                             s0_read_readdata[63:0], ed[63:0]); end
            end
            step();
            if (k == 0) begin
                m0_rvalid = 1'b0;
                @(negedge clk);
                n_checks++; if (m0_arvalid !== 1'b1) begin n_fail++;
                    $display("FAIL ro_released: got %b want 1", m0_arvalid); end
                exp_rdata_q.push_back(rd_pattern(base + 36'(4 * 64), 0));
                step();
                s0_read_read = 1'b0;
            end
        end
        m0_rvalid = 1'b0; m0_rlast = 1'b0;
        @(negedge clk);
        n_checks++; if (rd_idle !== 1'b1 || exp_rdata_q.size() != 0) begin n_fail++;
            $display("FAIL ro_drained: got idle=%b left=%0d want 1 0", rd_idle, exp_rdata_q.size());
        end
        step();
    endtask

    task automatic test_errors();
        s1_write_address = 36'h0_0000_2000; s1_write_burstcount = 8'd1; s1_write_write = 1'b1;
        m0_awready = 1'b1; m0_wready = 1'b1;
        step();
        step();
        s1_write_write = 1'b0;
        m0_bvalid = 1'b1; m0_bresp = 2'b10;
        @(negedge clk);
        n_checks++; if (wr_err !== 1'b0) begin n_fail++;
            $display("FAIL er_wr_early: got %b want 0", wr_err); end
        step();
        m0_bvalid = 1'b0; m0_bresp = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (wr_err !== 1'b1 || wr_idle !== 1'b1) begin n_fail++;
                $display("FAIL er_wr_sticky: got err=%b idle=%b want 1 1", wr_err, wr_idle); end
            step();
        end
        s0_read_address = 36'h0_0000_3000; s0_read_burstcount = 8'd1; s0_read_read = 1'b1;
        m0_arready = 1'b1;
        step();
        s0_read_read = 1'b0;
        m0_rvalid = 1'b1; m0_rlast = 1'b1; m0_rresp = 2'b11; err_clear = 1'b1;
        step();
        m0_rvalid = 1'b0; m0_rlast = 1'b0; m0_rresp = 2'b00; err_clear = 1'b0;
        @(negedge clk);
        n_checks++; if ({wr_err, rd_err, rd_idle} !== 3'b011) begin n_fail++;
            $display("FAIL er_clear_vs_set: got wr=%b rd=%b idle=%b want 0 1 1",
                     wr_err, rd_err, rd_idle); end
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        // Spurious responses with nothing outstanding; EXOKAY must not flag an error
        m0_rvalid = 1'b1; m0_rlast = 1'b1; m0_rresp = 2'b01; m0_bvalid = 1'b1; m0_bresp = 2'b01;
        step();
        m0_rvalid = 1'b0; m0_rlast = 1'b0; m0_bvalid = 1'b0;
        @(negedge clk);
        n_checks++; if ({wr_err, rd_err, wr_idle, rd_idle} !== 4'b0011) begin n_fail++;
            $display("FAIL er_spurious: got %b want 0011", {wr_err, rd_err, wr_idle, rd_idle}); end
        step();
    endtask

    task automatic test_reset_midburst();
        s1_write_address = 36'h0_0000_4000; s1_write_burstcount = 8'd4; s1_write_write = 1'b1;
        m0_awready = 1'b1; m0_wready = 1'b1;
        step();
        step();
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if ({m0_wvalid, m0_awvalid, s1_write_waitrequest, wr_idle} !== 4'b0011) begin
            n_fail++; $display("FAIL rm_abandon: got %b want 0011",
                               {m0_wvalid, m0_awvalid, s1_write_waitrequest, wr_idle}); end
        step();
        reset = 1'b0; s1_write_burstcount = 8'd1;
        @(negedge clk);
        n_checks++; if (m0_awvalid !== 1'b1 || m0_awlen !== 8'd0 || m0_wvalid !== 1'b0) begin
            n_fail++; $display("FAIL rm_restart: got v=%b len=%0d wvalid=%b want 1 0 0",
                               m0_awvalid, m0_awlen, m0_wvalid); end
        step();
        @(negedge clk);
        n_checks++; if (m0_wlast !== 1'b1) begin n_fail++;
            $display("FAIL rm_wlast: got %b want 1", m0_wlast); end
        step();
        s1_write_write = 1'b0; m0_bvalid = 1'b1; m0_bresp = 2'b00;
        step();
        m0_bvalid = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        s0_read_address = '0; s0_read_read = 1'b0; s0_read_byteenable = '1;
        s0_read_burstcount = 8'd1; s1_write_address = '0; s1_write_write = 1'b0;
        s1_write_byteenable = '1; s1_write_writedata = '0; s1_write_burstcount = 8'd1;
        m0_awready = 1'b0; m0_wready = 1'b0; m0_bid = 1'b0; m0_bresp = 2'b00; m0_bvalid = 1'b0;
        m0_arready = 1'b0; m0_rid = 1'b0; m0_rdata = '0; m0_rresp = 2'b00; m0_rlast = 1'b0;
        m0_rvalid = 1'b0; err_clear = 1'b0; reset = 1'b1;
        test_reset();
        test_single_write();
        test_burst_write();
        test_wr_outstanding();
        test_read_burst();
        test_rd_outstanding();
        test_errors();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
